// File: rtl/seq_det_pkg.sv
// Shared constants and types for the serial pattern detector.
// Holds the 7-segment glyph table for hex digits 0-F and the DP bit position.
package seq_det_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_DP = 7;

    // Active-high segments a..g in bits 6:0; DP (bit 7) is off in every glyph.
    localparam seg_t SEG_HEX [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex digit to 7-segment decoder (segments a..g, active-high).
module hex_to_seg
    import seq_det_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_HEX[digit][6:0];
    end

endmodule

// File: rtl/param_seq_detector.sv
// Parametrised serial pattern detector with saturating hit counter and 7-segment readout.
// Optional build macro SEQ_DET_MASK_EN adds a per-bit don't-care mask (pat_mask) loaded with pat_ld.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             cnt_clr,
    output logic             detect,
    output logic [CNT_W-1:0] hit_count,
    output seg_t             seg
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Only the newest PAT_W-1 bits are kept; the incoming x completes the window.
    logic [PAT_W-2:0] shreg_q, shreg_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] care;
    logic [PAT_W-1:0] window;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             detect_q;
    seg_t             seg_q, seg_d;
    logic             match;
    logic [6:0]       glyph;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = pat_ld ? pat_mask : mask_q;
        care   = ~mask_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end
`else
    always_comb begin
        care = '1;
    end
`endif

    always_comb begin
        window = {shreg_q, x};
        match  = en && !pat_ld && (fill_q >= FILL_ARM)
                 && (((window ^ pattern_q) & care) == '0);
    end

    always_comb begin
        shreg_d   = shreg_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        if (pat_ld) begin
            pattern_d = pat_in;
            shreg_d   = '0;
            fill_d    = '0;
        end else if (en) begin
            if (match && (OVERLAP == 1'b0)) begin
                shreg_d = '0;
                fill_d  = '0;
            end else begin
                shreg_d = window[PAT_W-2:0];
                fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
            end
        end
    end

    always_comb begin
        hit_d = hit_q;
        if (cnt_clr)
            hit_d = '0;
        else if (match && (hit_q != CNT_MAX))
            hit_d = hit_q + CNT_W'(1);
    end

    hex_to_seg u_hex_to_seg (
        .digit (4'(hit_d)),
        .glyph (glyph)
    );

    // Display tracks next-state values so the DP lines up with detect.
    always_comb begin
        seg_d         = {1'b0, glyph};
        seg_d[SEG_DP] = match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN;
            hit_q     <= '0;
            detect_q  <= 1'b0;
            seg_q     <= SEG_HEX[0];
        end else begin
            shreg_q   <= shreg_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            hit_q     <= hit_d;
            detect_q  <= match;
            seg_q     <= seg_d;
        end
    end

    assign detect    = detect_q;
    assign hit_count = hit_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench: overlapping and non-overlapping instances driven in parallel,
// table vectors, corner-case sequences and randomized stimulus against a queue model.
module tb_param_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       x;
    logic       pat_ld;
    logic [3:0] pat_in;
    logic [3:0] pat_mask_v;
    logic       cnt_clr;

    logic       det_ov, det_no;
    logic [3:0] cnt_ov, cnt_no;
    logic [7:0] seg_ov, seg_no;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_seq_detector #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(4)) u_ov (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .pat_ld    (pat_ld),
        .pat_in    (pat_in),
`ifdef SEQ_DET_MASK_EN
        .pat_mask  (pat_mask_v),
`endif
        .cnt_clr   (cnt_clr),
        .detect    (det_ov),
        .hit_count (cnt_ov),
        .seg       (seg_ov)
    );

    param_seq_detector #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(4)) u_no (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .pat_ld    (pat_ld),
        .pat_in    (pat_in),
`ifdef SEQ_DET_MASK_EN
        .pat_mask  (pat_mask_v),
`endif
        .cnt_clr   (cnt_clr),
        .detect    (det_no),
        .hit_count (cnt_no),
        .seg       (seg_no)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: index 0 = overlapping, 1 = non-overlapping.
    bit         hist [2][$];
    logic [3:0] m_pat;
    logic [3:0] m_mask;
    logic       m_det [2];
    logic [3:0] m_cnt [2];

    task automatic model_reset();
        m_pat  = 4'b1010;
        m_mask = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            hist[k].delete();
            m_det[k] = 1'b0;
            m_cnt[k] = 4'd0;
        end
    endtask

    task automatic model_step(input logic e, input logic xx, input logic ld,
                              input logic [3:0] pin, input logic [3:0] msk, input logic clr);
        logic [3:0] win;
        if (ld) begin
            m_pat  = pin;
            m_mask = msk;
        end
        for (int k = 0; k < 2; k++) begin
            m_det[k] = 1'b0;
            if (ld) begin
                hist[k].delete();
            end else if (e) begin
                hist[k].push_back(xx);
                if (hist[k].size() > 4) void'(hist[k].pop_front());
                if (hist[k].size() == 4) begin
                    win = 4'd0;
                    for (int i = 0; i < 4; i++) win = {win[2:0], hist[k][i]};
                    if (((win ^ m_pat) & ~m_mask) == 4'd0) begin
                        m_det[k] = 1'b1;
                        if (k == 1) hist[k].delete();
                    end
                end
            end
            if (clr)
                m_cnt[k] = 4'd0;
            else if (m_det[k] && m_cnt[k] != 4'd15)
                m_cnt[k] = m_cnt[k] + 4'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic xx, input logic ld,
                        input logic [3:0] pin, input logic [3:0] msk, input logic clr);
        en = e; x = xx; pat_ld = ld; pat_in = pin; pat_mask_v = msk; cnt_clr = clr;
        @(posedge clk);
        #1;
        model_step(e, xx, ld, pin, msk, clr);
    endtask

    task automatic chk_both(input string nm, input logic dov, input logic [3:0] cov,
                            input logic dno, input logic [3:0] cno);
        chk({nm, " det_ov"}, {7'd0, det_ov}, {7'd0, dov});
        chk({nm, " cnt_ov"}, {4'd0, cnt_ov}, {4'd0, cov});
        chk({nm, " seg_ov"}, seg_ov, {dov, glyph[cov]});
        chk({nm, " det_no"}, {7'd0, det_no}, {7'd0, dno});
        chk({nm, " cnt_no"}, {4'd0, cnt_no}, {4'd0, cno});
        chk({nm, " seg_no"}, seg_no, {dno, glyph[cno]});
    endtask

    typedef struct {
        logic       en, x, ld;
        logic [3:0] pin;
        logic       clr;
        logic       dov;
        logic [3:0] cov;
        logic       dno;
        logic [3:0] cno;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; en = 0; x = 0; pat_ld = 0; pat_in = 0; pat_mask_v = 0; cnt_clr = 0;
        model_reset();

        // Overlap / non-overlap on 1,0,1,0,1,0
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 1, 1, 1, 1});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 1, 2, 0, 1});
        tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 2, 0, 1});
        // Reload 1100 with x=1 discarded; 1,0,0 must not match
        tbl.push_back('{1, 1, 1, 4'hC, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 2, 0, 1});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 1, 3, 1, 2});
        // Old pattern no longer matches
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 3, 0, 2});
        // Restore 1010 with en low, then en toggles between pattern bits
        tbl.push_back('{0, 0, 1, 4'hA, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{0, 1, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{0, 0, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 1, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{0, 1, 0, 4'h0, 0, 0, 3, 0, 2});
        tbl.push_back('{1, 0, 0, 4'h0, 0, 1, 4, 1, 3});
        tbl.push_back('{0, 1, 0, 4'h0, 0, 0, 4, 0, 3});

        #3;
        chk_both("reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].x, tbl[i].ld, tbl[i].pin, 4'h0, tbl[i].clr);
            chk_both($sformatf("tbl[%0d]", i), tbl[i].dov, tbl[i].cov, tbl[i].dno, tbl[i].cno);
        end

        // Saturation: 20 passes of 1010 (at least 20 matches in each instance)
        for (int r = 0; r < 20; r++) begin
            step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
            step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk_both("saturate", 0, 15, 0, 15);

        // Clear wins over a coincident match
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        chk_both("clr_vs_match", 1, 0, 1, 0);

        // Async reset mid-stream drops a runtime pattern
        step(1, 0, 1, 4'hC, 0, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_both("pre_reset", 1, 1, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_both("async_reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(1, 1, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        chk_both("old_pat_lost", 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        chk_both("reset_pat", 1, 1, 1, 1);

`ifdef SEQ_DET_MASK_EN
        step(0, 0, 1, 4'hA, 4'h1, 1);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_both("mask_1010", 1, 1, 1, 1);
        step(0, 0, 1, 4'hA, 4'h1, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk_both("mask_1011", 1, 2, 1, 2);
        step(0, 0, 1, 4'hA, 4'h1, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_both("mask_1000", 0, 2, 0, 2);
`endif

        // Randomized run against the queue model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] msk;
            msk = 4'h0;
`ifdef SEQ_DET_MASK_EN
            msk = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
`endif
            step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(40) == 0),
                 4'($urandom), msk, ($urandom_range(50) == 0));
            chk_both($sformatf("rand[%0d]", i), m_det[0], m_cnt[0], m_det[1], m_cnt[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
